// File: rtl/pandas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pandas_pkg
//  Description : Shared ALU datapath types and constants: operand/result
//                width, command field width and the NOP command code.
//  Revision    : 1.0 - initial release
// ============================================================================
package pandas_pkg;

  localparam int NUM_SIZE      = 32;
  localparam int CMD_SIZE_LOG2 = 3;
  localparam int CMD_SIZE      = 2 ** CMD_SIZE_LOG2;

  typedef logic [CMD_SIZE-1:0] cmd_t;
  typedef logic [NUM_SIZE-1:0] num_t;

  localparam cmd_t CMD_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the first eligible
//                index at or after the pointer, wrapping around N.
//  Ports       : i_eligible  - candidate mask
//                i_rr_ptr    - search start index (state held by the caller)
//                o_grant     - one-hot grant, zero when nothing is eligible
//                o_grant_idx - encoded index of o_grant
//                o_grant_vld - any grant issued
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_eligible,
  input  logic [IDXW-1:0] i_rr_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IDXW-1:0] o_grant_idx,
  output logic            o_grant_vld
);

  // One extra bit so ptr + k (< 2N) never overflows before the wrap.
  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(N)) begin
        w_sum = w_sum - (IDXW+1)'(N);
      end
      w_idx = w_sum[IDXW-1:0];
      if (!o_grant_vld && i_eligible[w_idx]) begin
        o_grant_vld    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin scheduler sharing one fixed-latency ALU between
//                NUM_REQ requesters, routing each result back to its owner.
//  Ports       : clk, reset                 - clock, async active-high reset
//                req_valid/req_ready        - per-requester op handshake
//                req_cmd/req_in1/req_in2    - per-requester op fields
//                rsp_valid/rsp_ready        - per-requester result handshake
//                rsp_data                   - per-requester result register
//                alu_cmd/alu_in1/alu_in2    - registered ALU inputs
//                alu_out                    - ALU result, ALU_LAT cycles later
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import pandas_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  cmd_t [NUM_REQ-1:0]   req_cmd,
  input  num_t [NUM_REQ-1:0]   req_in1,
  input  num_t [NUM_REQ-1:0]   req_in2,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output num_t [NUM_REQ-1:0]   rsp_data,
  output cmd_t                 alu_cmd,
  output num_t                 alu_in1,
  output num_t                 alu_in2,
  input  num_t                 alu_out
);

  localparam int TAGW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_busy;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [TAGW-1:0]    w_gidx;
  logic               w_accept;

  logic [TAGW-1:0]    r_ptr;
  logic [ALU_LAT:0]   r_tag_vld;
  logic [TAGW-1:0]    r_tag [ALU_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  num_t [NUM_REQ-1:0] r_rsp_data;
  cmd_t               r_alu_cmd;
  num_t               r_alu_in1;
  num_t               r_alu_in2;

  // A requester stays busy from the cycle after its accept until the cycle
  // after its response handshake: the tag pipeline covers the in-flight part
  // and the held rsp_valid covers the rest, including the handshake cycle.
  always_comb begin
    w_busy = r_rsp_valid;
    for (int s = 0; s <= ALU_LAT; s++) begin
      if (r_tag_vld[s]) begin
        w_busy[r_tag[s]] = 1'b1;
      end
    end
  end

  assign w_elig = req_valid & ~w_busy;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDXW (TAGW)
  ) u_rr_arbiter (
    .i_eligible  (w_elig),
    .i_rr_ptr    (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_grant_vld (w_accept)
  );

  // Gate with reset so the ready outputs read zero as soon as reset rises.
  assign req_ready = w_grant & {NUM_REQ{~reset}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_alu_cmd <= CMD_NOP;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
    end else if (w_accept) begin
      r_ptr     <= (w_gidx == TAGW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
      r_alu_cmd <= req_cmd[w_gidx];
      r_alu_in1 <= req_in1[w_gidx];
      r_alu_in2 <= req_in2[w_gidx];
    end else begin
      // Operands hold to avoid needless toggling on the ALU inputs.
      r_alu_cmd <= CMD_NOP;
    end
  end

  // Tag pipeline: stage s is visible s+1 cycles after the accept, so the last
  // stage lines up with alu_out for the same operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= ALU_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag[0]     <= w_gidx;
      for (int s = 1; s <= ALU_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag[s]     <= r_tag[s-1];
      end
    end
  end

  // A result can never land on a requester still holding one (one op
  // outstanding each), so set and clear never collide for the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_tag_vld[ALU_LAT] && (r_tag[ALU_LAT] == TAGW'(i))) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= alu_out;
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_cmd   = r_alu_cmd;
  assign alu_in1   = r_alu_in1;
  assign alu_in2   = r_alu_in2;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a fixed-latency
//                ALU model and a transaction-level reference of grants,
//                ALU inputs and per-requester results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import pandas_pkg::*;

  parameter int N   = 4;
  parameter int LAT = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  cmd_t [N-1:0] req_cmd;
  num_t [N-1:0] req_in1;
  num_t [N-1:0] req_in2;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  num_t [N-1:0] rsp_data;
  cmd_t         alu_cmd;
  num_t         alu_in1;
  num_t         alu_in2;
  num_t         alu_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter #(.NUM_REQ(N), .ALU_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_cmd   (alu_cmd),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_out   (alu_out)
  );

  function automatic num_t alu_f(cmd_t c, num_t a, num_t b);
    case (c)
      8'd1:    return a + b;
      8'd2:    return a - b;
      default: return a ^ b ^ {24'h0, c};
    endcase
  endfunction

  generate
    if (LAT == 0) begin : g_alu_comb
      assign alu_out = alu_f(alu_cmd, alu_in1, alu_in2);
    end else begin : g_alu_pipe
      num_t alu_pipe [LAT];
      always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_cmd, alu_in1, alu_in2);
        for (int s = 1; s < LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
      end
      assign alu_out = alu_pipe[LAT-1];
    end
  endgenerate

  // ---------------- reference model (transaction level) ----------------
  int           m_ptr;
  bit   [N-1:0] m_busy;
  bit   [N-1:0] m_rspv;
  int           m_due [N];
  num_t         m_res [N];
  num_t         m_rspd [N];
  cmd_t         m_cmd;
  num_t         m_in1, m_in2;

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_rspv = '0; m_cmd = '0; m_in1 = '0; m_in2 = '0;
    for (int i = 0; i < N; i++) begin m_due[i] = 0; m_res[i] = '0; m_rspd[i] = '0; end
  endtask

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_grant;
    if (mon_en) begin
      if (reset) begin
        model_reset();
        checks++;
        if ({req_ready, rsp_valid, alu_cmd, alu_in1, alu_in2, rsp_data} !== '0) begin
          errors++;
          $display("FAIL mon_reset: outputs not zero at t=%0t rdy=%b rv=%b cmd=%0d", $time, req_ready, rsp_valid, alu_cmd);
        end
      end else begin
        for (int i = 0; i < N; i++)
          if (m_busy[i] && !m_rspv[i] && cyc == m_due[i]) begin
            m_rspv[i] = 1'b1; m_rspd[i] = m_res[i];
          end
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N] && !m_busy[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        checks++;
        if (req_ready !== exp_grant) begin
          errors++;
          $display("FAIL mon_grant cyc=%0d: got %b, want %b", cyc, req_ready, exp_grant);
        end
        checks++;
        if ({alu_cmd, alu_in1, alu_in2} !== {m_cmd, m_in1, m_in2}) begin
          errors++;
          $display("FAIL mon_alu cyc=%0d: got %0d/%h/%h, want %0d/%h/%h", cyc, alu_cmd, alu_in1, alu_in2, m_cmd, m_in1, m_in2);
        end
        checks++;
        if (rsp_valid !== m_rspv) begin
          errors++;
          $display("FAIL mon_rsp_valid cyc=%0d: got %b, want %b", cyc, rsp_valid, m_rspv);
        end
        for (int i = 0; i < N; i++) begin
          checks++;
          if (rsp_data[i] !== m_rspd[i]) begin
            errors++;
            $display("FAIL mon_rsp_data[%0d] cyc=%0d: got %h, want %h", i, cyc, rsp_data[i], m_rspd[i]);
          end
        end
        // advance model to the next cycle
        for (int i = 0; i < N; i++)
          if (m_rspv[i] && rsp_ready[i]) begin m_rspv[i] = 1'b0; m_busy[i] = 1'b0; end
        if (g >= 0) begin
          m_cmd = req_cmd[g]; m_in1 = req_in1[g]; m_in2 = req_in2[g];
          m_ptr = (g + 1) % N;
          m_busy[g] = 1'b1;
          m_due[g]  = cyc + LAT + 2;
          m_res[g]  = alu_f(req_cmd[g], req_in1[g], req_in2[g]);
        end else begin
          m_cmd = '0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      req_cmd[i] = 8'($urandom_range(1, 255));
      req_in1[i] = $urandom;
      req_in2[i] = $urandom;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = '0; rand_fields();
    #12;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, want 0", req_ready); end
    checks++;
    if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b, want 0", rsp_valid); end
    checks++;
    if ({alu_cmd, alu_in1, alu_in2} !== '0) begin errors++; $display("FAIL reset_alu: got %0d/%h/%h, want 0", alu_cmd, alu_in1, alu_in2); end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h, want 0", rsp_data); end
    model_reset();
    mon_en = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single_op();
    @(posedge clk); #1;
    req_valid = 4'b0001; req_cmd[0] = 8'd1; req_in1[0] = 32'd5; req_in2[0] = 32'd7; rsp_ready = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if ({alu_cmd, alu_in1, alu_in2} !== {8'd1, 32'd5, 32'd7}) begin
      errors++; $display("FAIL single_alu: got %0d/%0d/%0d, want 1/5/7", alu_cmd, alu_in1, alu_in2);
    end
    repeat (LAT + 1) @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd12) begin
      errors++; $display("FAIL single_rsp: got v=%b d=%0d, want v=1 d=12", rsp_valid[0], rsp_data[0]);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_all_rotate();
    int exp_next = 0;
    int grants = 0;
    apply_reset();
    rsp_ready = '1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      req_valid = '1; rand_fields();
      @(negedge clk);
      if (req_ready != '0) begin
        checks++;
        if (req_ready !== (4'b0001 << exp_next)) begin
          errors++; $display("FAIL rotate_order: got %b, want index %0d", req_ready, exp_next);
        end
        exp_next = (exp_next + 1) % N;
        grants++;
      end
    end
    checks++;
    if (grants < (40 * N) / (LAT + 3) - N) begin
      errors++; $display("FAIL rotate_count: got %0d grants, want >= %0d", grants, (40 * N) / (LAT + 3) - N);
    end
  endtask

  task automatic test_backpressure();
    int others = 0;
    int got2 = -1;
    rsp_ready = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1; req_valid = '1; rand_fields();
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; req_valid = '1; rand_fields();
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b1) begin
        errors++; $display("FAIL bp_hold: got rdy2=%b rv2=%b, want 0/1", req_ready[2], rsp_valid[2]);
      end
      if (req_ready != '0) others++;
    end
    checks++;
    if (others < 3) begin errors++; $display("FAIL bp_others: got %0d grants, want >= 3", others); end
    @(posedge clk); #1; rsp_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_handshake_cycle: got rdy2=%b, want 0", req_ready[2]); end
    @(posedge clk); #1; rsp_ready[2] = 1'b0;
    for (int c = 0; c < 2 * N && got2 < 0; c++) begin
      @(negedge clk);
      if (req_ready[2]) got2 = c;
      @(posedge clk); #1; rand_fields();
    end
    checks++;
    if (got2 < 0) begin errors++; $display("FAIL bp_regrant: got none, want grant to 2 within %0d cycles", 2 * N); end
    rsp_ready = '1;
  endtask

  task automatic test_idle();
    @(posedge clk); #1; req_valid = '0; rsp_ready = '1;
    repeat (LAT + 4) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (alu_cmd !== 8'd0 || rsp_valid !== '0) begin
        errors++; $display("FAIL idle: got cmd=%0d rv=%b, want 0/0", alu_cmd, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom); rsp_ready = 4'($urandom); rand_fields();
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1; req_valid = 4'b1010; rsp_ready = '1; rand_fields();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, alu_cmd, alu_in1, alu_in2, rsp_data} !== '0) begin
      errors++; $display("FAIL async_reset: got rdy=%b rv=%b cmd=%0d, want all 0", req_ready, rsp_valid, alu_cmd);
    end
    @(posedge clk); #2;
    reset = 1'b0; req_valid = '0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin errors++; $display("FAIL async_stale: got rv=%b, want 0", rsp_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_op();
    test_all_rotate();
    test_backpressure();
    test_idle();
    test_random();
    test_async_reset();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin scheduler sharing one ALU datapath (cmd/in1/in2 -> out) between NUM_REQ requesters. Each requester issues operations over a valid/ready request channel and collects its result over a valid/ready response channel. The block drives the ALU's cmd/in1/in2 inputs and routes its out result back to the owning requester. It sits between the host-side command front end and the ALU.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- NUM_SIZE, 32: operand/result width (package constant)
- CMD_SIZE_LOG2, 3: command field is 2**CMD_SIZE_LOG2 bits (package constant)
- ALU_LAT, 1: fixed ALU latency in cycles from alu_* inputs to alu_out; 0 = combinational. ALU accepts one op per cycle.

- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_cmd  in  NUM_REQ x 2**CMD_SIZE_LOG2  per-requester command
- req_in1, req_in2  in  NUM_REQ x NUM_SIZE  per-requester operands
- rsp_valid  out  NUM_REQ  result held for requester
- rsp_ready  in  NUM_REQ  requester consumes result
- rsp_data  out  NUM_REQ x NUM_SIZE  result per requester
- alu_cmd  out  2**CMD_SIZE_LOG2  to ALU cmd
- alu_in1, alu_in2  out  NUM_SIZE  to ALU operands
- alu_out  in  NUM_SIZE  from ALU out

## Operation
- busy[i] = op of requester i in flight OR rsp_valid[i]. One outstanding op per requester.
- eligible = req_valid & ~busy. The grant is the first eligible bit at or after rr_ptr, wrapping. req_ready = grant (one-hot or zero). req_ready depends combinationally on req_valid.
- An accept occurs when req_valid[i] & req_ready[i].
- On accept:
  - alu_cmd/alu_in1/alu_in2 register the granted requester's fields.
  - rr_ptr <= (granted index + 1) mod NUM_REQ.
  - Requester ID enters a tag pipeline of depth ALU_LAT+1 with a valid bit.
- No accept in a cycle: alu_cmd registers CMD_NOP (0). alu_in1/alu_in2 hold their values. A bubble enters the tag pipeline. rr_ptr holds.
- When the tag pipeline output is valid, rsp_data[tag] <= alu_out and rsp_valid[tag] <= 1.
- rsp_valid[i] clears on rsp_valid[i] & rsp_ready[i]. rsp_data[i] holds its value until overwritten.
- Re-grant of requester i is allowed earliest in the cycle after its response handshake, because busy still covers the handshake cycle.
- No arithmetic is performed; operands and result pass through bit-exact.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, alu_cmd 0, alu_in1 0, alu_in2 0, rr_ptr 0, tag pipeline empty.
- Accept in cycle t -> alu_* valid in cycle t+1 -> alu_out sampled at the end of cycle t+1+ALU_LAT -> rsp_valid high in cycle t+2+ALU_LAT. Request-to-response latency is ALU_LAT+2.
- Throughput is one op per cycle across requesters. A single requester can issue at most once per ALU_LAT+3 cycles when rsp_ready is tied high.
- Response backpressure stalls only that requester. Other requesters keep issuing.
- Reset asserted mid-operation: all in-flight ops are discarded and their results never appear. Outputs return to reset values immediately, without waiting for a clock edge.
- Simultaneous requests from all requesters: grants rotate strictly, with no requester granted twice before all others that remain eligible.

## Structure
- Shared package pandas_pkg holds: NUM_SIZE, CMD_SIZE_LOG2, typedef cmd_t (logic [2**CMD_SIZE_LOG2-1:0]), typedef num_t (logic [NUM_SIZE-1:0]), CMD_NOP = '0.
- Sub-module rr_arbiter (parameter N): inputs eligible and rr_ptr, outputs a one-hot grant and its encoded index. Purely combinational; rr_ptr state stays in alu_arbiter.
- The tag pipeline and per-requester result registers live in alu_arbiter.

## Test plan
- Reset, then a single op: requester 0 sends cmd=1, in1=5, in2=7. req_ready[0] is high in the same cycle. alu_cmd=1, alu_in1=5, alu_in2=7 appear the next cycle. With ALU_LAT=1, the ALU model returns 12, and rsp_valid[0]=1 with rsp_data[0]=12 exactly 3 cycles after the accept.
- All 4 requesters hold req_valid from reset with rsp_ready=1: grant order is 0,1,2,3,0,…. alu_cmd is never NOP while any requester is eligible.
- Requester 2 holds rsp_ready=0 after its result: no further grant to requester 2. Requesters 0, 1 and 3 keep being served. After a rsp_ready pulse, requester 2 is granted again no earlier than the next cycle.
- Idle cycles: with no req_valid, alu_cmd=0 and no rsp_valid ever rises.
- Reset asserted asynchronously while 2 ops are in flight: all outputs go to 0 before the next edge. After release, no stale rsp_valid appears.
- ALU_LAT=0 and ALU_LAT=3 builds: latency is 2 and 5 cycles respectively, and results are routed to the correct requester under back-to-back grants.
